// File: rtl/bfp_normalize_pkg.sv
// Shared constants and the output beat type for the block-floating-point normalizer.
package bfp_normalize_pkg;

    localparam int MANT_W  = 24;
    localparam int EXP_W   = 7;
    localparam int EXP_MIN = -64;
    localparam int EXP_MAX = 63;

    typedef struct packed {
        logic signed [MANT_W-1:0] mant;
        logic signed [EXP_W-1:0]  quant_bit;
        logic                     zero_out;
        logic                     uflow;
    } beat_t;

endpackage

// File: rtl/clz_sign.sv
// Leading-sign counter: number of leading bits equal to the MSB, minus one.
module clz_sign #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]         word,
    output logic [$clog2(W)-1:0] count
);

    localparam int unsigned CW = $clog2(W);

    logic found;

    always_comb begin
        count = CW'(W - 1);
        found = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            if (!found && (word[i] != word[W-1])) begin
                count = CW'(W - 2 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bfp_normalize.sv
// Two-stage normalizer: S1 registers the input and its leading-sign count, S2 shifts,
// adjusts the exponent, checks underflow and holds the output beat.
module bfp_normalize
    import bfp_normalize_pkg::*;
#(
    parameter int unsigned IN_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   din,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant,
    output logic [EXP_W-1:0]  quant_bit,
    output logic              zero_out,
    output logic              uflow
);

    localparam int unsigned CW = $clog2(IN_W);
    // Wide enough for EXP_MIN - (IN_W-1) without wrapping.
    localparam int unsigned EW = EXP_W + CW + 1;
    localparam logic signed [EW-1:0] E_MIN = EW'(EXP_MIN);

    logic             s1_valid_q;
    logic [IN_W-1:0]  s1_din_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [CW-1:0]    s1_lzc_q;
    logic [CW-1:0]    lzc;

    logic             out_valid_q;
    beat_t            beat_q;
    beat_t            beat_d;
    logic signed [EW-1:0] e_wide;

    logic s2_advance;
    logic s1_advance;

    assign s2_advance = !out_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_advance;
    assign in_ready   = !s1_valid_q || s1_advance;

    clz_sign #(
        .W (IN_W)
    ) u_clz_sign (
        .word  (din),
        .count (lzc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_din_q   <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_din_q <= din;
                s1_exp_q <= in_exp;
                s1_lzc_q <= lzc;
            end
        end
    end

    always_comb begin
        e_wide = {{(EW-EXP_W){s1_exp_q[EXP_W-1]}}, s1_exp_q} - EW'(s1_lzc_q);
        beat_d = '0;
        if (s1_din_q == '0) begin
            beat_d.zero_out = 1'b1;
        end else if (e_wide < E_MIN) begin
            beat_d.zero_out = 1'b1;
            beat_d.uflow    = 1'b1;
        end else begin
            // Truncate the normalized word to its top MANT_W bits, no rounding.
            beat_d.mant      = MANT_W'((s1_din_q << s1_lzc_q) >> (IN_W - MANT_W));
            beat_d.quant_bit = e_wide[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (s2_advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                beat_q <= beat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign mant      = beat_q.mant;
    assign quant_bit = beat_q.quant_bit;
    assign zero_out  = beat_q.zero_out;
    assign uflow     = beat_q.uflow;

endmodule

// File: tb/tb_bfp_normalize.sv
// Scoreboard bench for bfp_normalize: directed vectors, stall, mid-stream reset, random traffic.
module tb_bfp_normalize;
    import bfp_normalize_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din = '0;
    logic [6:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] mant;
    logic [6:0]  quant_bit;
    logic        zero_out;
    logic        uflow;

    int n_tests = 0;
    int n_fail = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by main
    int n_out = 0;
    beat_t sb[$];

    typedef struct packed {
        logic [31:0] d;
        int          e;
        logic [23:0] m;
        int          q;
        logic        z;
        logic        u;
    } vec_t;

    vec_t vecs [0:16] = '{
        '{32'h40000000,   0, 24'h400000,   0, 1'b0, 1'b0},
        '{32'h00000001,   5, 24'h400000, -25, 1'b0, 1'b0},
        '{32'hFFFFFFFF,   0, 24'h800000, -31, 1'b0, 1'b0},
        '{32'h00000000,  10, 24'h000000,   0, 1'b1, 1'b0},
        '{32'h00000001, -40, 24'h000000,   0, 1'b1, 1'b1},
        '{32'h00000001, -34, 24'h400000, -64, 1'b0, 1'b0},
        '{32'h00000001, -35, 24'h000000,   0, 1'b1, 1'b1},
        '{32'h40000000,  63, 24'h400000,  63, 1'b0, 1'b0},
        '{32'h80000000,  63, 24'h800000,  63, 1'b0, 1'b0},
        '{32'h40000000, -64, 24'h400000, -64, 1'b0, 1'b0},
        '{32'h12345678,   0, 24'h48D159,  -2, 1'b0, 1'b0},
        '{32'hF0000000,   4, 24'h800000,   1, 1'b0, 1'b0},
        '{32'hFFFF8000,   0, 24'h800000, -16, 1'b0, 1'b0},
        '{32'hC0001234,   0, 24'h800024,  -1, 1'b0, 1'b0},
        '{32'h00000100, -34, 24'h400000, -56, 1'b0, 1'b0},
        '{32'hFFFFFFFF, -40, 24'h000000,   0, 1'b1, 1'b1},
        '{32'h7FFFFFFF,   0, 24'h7FFFFF,   0, 1'b0, 1'b0}
    };

    always #5 clk = ~clk;

    bfp_normalize #(
        .IN_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant      (mant),
        .quant_bit (quant_bit),
        .zero_out  (zero_out),
        .uflow     (uflow)
    );

    function automatic beat_t mk(input logic [23:0] m, input int q, input logic z, input logic u);
        beat_t b;
        b.mant      = m;
        b.quant_bit = 7'(q);
        b.zero_out  = z;
        b.uflow     = u;
        return b;
    endfunction

    // Independent reference: count sign run bit by bit, then shift and scale.
    function automatic beat_t model(input logic [31:0] d, input logic [6:0] e);
        int          lz;
        int          ee;
        logic [31:0] sh;
        if (d == 32'h0) return mk(24'h0, 0, 1'b1, 1'b0);
        lz = 0;
        for (int i = 30; i >= 0; i--) begin
            if (d[i] != d[31]) break;
            lz++;
        end
        sh = d << lz;
        ee = int'($signed(e)) - lz;
        if (ee < -64) return mk(24'h0, 0, 1'b1, 1'b1);
        return mk(sh[31:8], ee, 1'b0, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [6:0] e, input beat_t want);
        int waitc = 0;
        in_valid = 1'b1;
        din      = d;
        in_exp   = e;
        @(negedge clk);
        while (!in_ready) begin
            waitc++;
            if (waitc > 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at 0, want 1");
                break;
            end
            @(negedge clk);
        end
        if (in_ready) sb.push_back(want);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 500) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops on every output transfer, and checks held outputs during stalls.
    beat_t cur;
    beat_t held;
    beat_t want_b;
    logic  held_v = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                cur.mant      = mant;
                cur.quant_bit = quant_bit;
                cur.zero_out  = zero_out;
                cur.uflow     = uflow;
                if (held_v) begin
                    n_tests++;
                    if (!out_valid || cur !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b beat=%h, want v=1 beat=%h",
                                 out_valid, cur, held);
                    end
                end
                if (out_valid && out_ready) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out: got beat %h, want no output", cur);
                    end else begin
                        want_b = sb.pop_front();
                        if (cur !== want_b) begin
                            n_fail++;
                            $display("FAIL beat%0d: got mant=%h qb=%0d z=%b u=%b, want mant=%h qb=%0d z=%b u=%b",
                                     n_out, cur.mant, cur.quant_bit, cur.zero_out, cur.uflow,
                                     want_b.mant, want_b.quant_bit, want_b.zero_out, want_b.uflow);
                        end
                    end
                    n_out++;
                end
                held_v = out_valid && !out_ready;
                held   = cur;
            end
        end
    end

    logic        saw_drop;
    logic [31:0] rd;
    logic [6:0]  re;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mant", 32'(mant), 32'd0);
        check("rst_quant_bit", 32'(quant_bit), 32'd0);
        check("rst_flags", {30'd0, zero_out, uflow}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency on an idle pipe
        send(vecs[0].d, 7'(vecs[0].e), mk(vecs[0].m, vecs[0].q, vecs[0].z, vecs[0].u));
        check("latency_c1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_c2", 32'(out_valid), 32'd1);
        drain();

        // Directed vectors back to back
        for (int i = 1; i < 17; i++) begin
            send(vecs[i].d, 7'(vecs[i].e), mk(vecs[i].m, vecs[i].q, vecs[i].z, vecs[i].u));
        end
        drain();

        // Stall: out_ready low in cycles 2..5 while 6 beats stream in
        saw_drop = 1'b0;
        fork
            begin
                for (int i = 1; i < 7; i++) begin
                    send(vecs[i].d, 7'(vecs[i].e), mk(vecs[i].m, vecs[i].q, vecs[i].z, vecs[i].u));
                end
            end
            begin
                ready_mode = 2;
                for (int c = 0; c < 8; c++) begin
                    out_ready = !(c >= 2 && c <= 5);
                    @(negedge clk);
                    if (!in_ready) saw_drop = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready  = 1'b1;
                ready_mode = 0;
            end
        join
        check("stall_in_ready_drop", 32'(saw_drop), 32'd1);
        drain();

        // Reset with two beats in flight
        send(32'h00000001, 7'd5, mk(24'h400000, -25, 1'b0, 1'b0));
        send(32'h40000000, 7'd0, mk(24'h400000, 0, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h20000000, 7'd3, mk(24'h400000, 2, 1'b0, 1'b0));
        drain();

        // Random traffic with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            rd = $urandom;
            rd = 32'($signed(rd) >>> $urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) rd = 32'h0;
            re = 7'($urandom);
            if (i % 50 == 0) re = 7'h40;
            if (i % 50 == 25) re = 7'h3F;
            send(rd, re, model(rd, re));
        end
        ready_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bfp_normalize.md
BFP_NORMALIZE -- requirements
Module: bfp_normalize

Interface
REQ-001 Parameter: IN_W, default 32, input word width (signed Q(IN_W-1)); SHALL be at least 24.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 in_valid  input  1  an input beat is present.
REQ-005 in_ready  output  1  the block accepts a beat this cycle.
REQ-006 din  input  IN_W  signed fixed-point value, Q(IN_W-1).
REQ-007 in_exp  input  7  signed exponent, -64..63; input value = din * 2^in_exp.
REQ-008 out_valid  output  1  an output beat is present.
REQ-009 out_ready  input  1  the consumer accepts the output beat.
REQ-010 mant  output  24  signed Q23 normalized mantissa, the reciprocal datapath's input format.
REQ-011 quant_bit  output  7  signed exponent, -64..63; output value = mant * 2^quant_bit.
REQ-012 zero_out  output  1  mant is zero (zero input or underflow).
REQ-013 uflow  output  1  exponent underflow forced a zero result.

Function
REQ-014 Transfer rules: an input transfer SHALL occur when in_valid&&in_ready; an output transfer SHALL occur when out_valid&&out_ready.
REQ-015 lzc SHALL equal the count of leading bits of din equal to din[IN_W-1], minus 1 (range 0..IN_W-1).
REQ-016 The normalized word SHALL be din<<lzc, and mant SHALL be its upper 24 bits, truncated with no rounding, so for nonzero din mant[23]!=mant[22] or mant==24'h800000.
REQ-017 Exponent: e = in_exp - lzc SHALL be computed at 8+ bits signed; if e >= -64 then quant_bit=e.
REQ-018 Underflow: if e < -64 then mant=0, quant_bit=0, zero_out=1, uflow=1.
REQ-019 Zero input: din==0 SHALL give mant=0, quant_bit=0, zero_out=1, uflow=0.
REQ-020 Pipeline: two register stages.
  - S1 captures din/in_exp and computes lzc.
  - S2 performs the shift, exponent subtract and underflow check, and drives the outputs from registers.
REQ-021 Latency: out_valid SHALL rise exactly 2 cycles after the accepting edge when never stalled.
REQ-022 Throughput: one beat per cycle while out_ready=1.
REQ-023 Backpressure: each stage SHALL advance only when it is empty or the downstream stage advances; in_ready = !s1_valid || s1_advance, combinational from registered state and out_ready only.
REQ-024 Stall: outputs SHALL hold stable while out_valid&&!out_ready; beats SHALL never be dropped, duplicated or reordered.
REQ-025 Simultaneous input and output transfers in one cycle with both stages full SHALL be lossless.
REQ-026 All-ones din (-1 LSB): lzc=IN_W-1, mant=24'h800000.

Reset
REQ-027 On rst_n low: s1_valid=0, out_valid=0, mant=0, quant_bit=0, zero_out=0, uflow=0; in_ready SHALL read 1 once rst_n is high.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; the first output after release SHALL correspond to the first beat accepted after release.

Structure
REQ-029 A shared package SHALL hold MANT_W=24, EXP_W=7, EXP_MIN=-64, EXP_MAX=63, and the beat struct {mant, quant_bit, zero_out, uflow}.
REQ-030 Leading-sign counting SHALL be one combinational sub-module, clz_sign (parameter W, input W-bit word, output count), instantiated in S1.
REQ-031 The block SHALL contain no other sub-modules; the barrel shift stays inline in S2.

Verification (IN_W=32)
REQ-032 din=32'h40000000, in_exp=0 -> mant=24'h400000, quant_bit=0, zero_out=0, out_valid 2 cycles after acceptance.
REQ-033 din=32'h00000001, in_exp=5 -> mant=24'h400000, quant_bit=-25; din=32'hFFFFFFFF, in_exp=0 -> mant=24'h800000, quant_bit=-31.
REQ-034 Zero and underflow cases:
  - din=0, in_exp=10 -> mant=0, quant_bit=0, zero_out=1, uflow=0.
  - din=32'h00000001, in_exp=-40 -> zero_out=1, uflow=1, quant_bit=0.
REQ-035 Stall test: 6 back-to-back beats, out_ready low for cycles 2-5.
  - in_ready drops once both stages hold beats.
  - Output holds stable during the stall.
  - All 6 outputs emerge in order, none lost or repeated.
REQ-036 Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid=0 immediately; after release, the beat din=32'h20000000, in_exp=3 -> mant=24'h400000, quant_bit=2 is the first output.
REQ-037 Random: 10k random din/in_exp with random out_ready, checked against a reference model; this SHALL include the extreme exponents in_exp=-64 and in_exp=63.
